// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit accesses
// on an external asynchronous SRAM. ready low freezes the pipeline while busy.
module sram_mem_ctrl #(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [16:0]     word_q;
    logic [15:0]     wdata_hi_q;
    logic            write_q;

    logic [31:0] offset_addr;
    logic [16:0] word_idx;
    logic        req;
    logic        unused_offset_bits;

    // Word index relative to the data-memory base; wraps modulo 2^32.
    assign offset_addr        = address - ADDR_OFFSET;
    assign word_idx           = offset_addr[18:2];
    assign unused_offset_bits = ^{offset_addr[31:19], offset_addr[1:0]};
    assign req                = rd_en | wr_en;

    // Freeze is the inverse of ready: released when idle or finishing.
    always_comb begin
        ready = ((state_q == StIdle) && !req) || (state_q == StDone);
    end

    // Access sequencer; pin outputs are registered so they are stable for a whole half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            write_q     <= 1'b0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        // Write wins when both requests are present.
                        state_q     <= StLow;
                        cnt_q       <= CntLoad;
                        word_q      <= word_idx;
                        wdata_hi_q  <= wdata[31:16];
                        write_q     <= wr_en;
                        sram_addr   <= {word_idx, 1'b0};
                        sram_we_n   <= ~wr_en;
                        sram_dq_oe  <= wr_en;
                        sram_dq_out <= wr_en ? wdata[15:0] : 16'h0000;
                    end
                end
                StLow: begin
                    if (cnt_q == '0) begin
                        if (!write_q) begin
                            rdata[15:0] <= sram_dq_in;
                        end
                        state_q     <= StHigh;
                        cnt_q       <= CntLoad;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= write_q ? wdata_hi_q : 16'h0000;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHigh: begin
                    if (cnt_q == '0) begin
                        if (!write_q) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                        state_q     <= StDone;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
